// File: rtl/control_unit_pkg.sv
// Shared definitions for the sequencer: widths, opcode values (the ALU codes
// are the same numbers the ALU decodes) and the FSM state type.
package control_unit_pkg;

   localparam int CU_PC_W    = 8;
   localparam int CU_INSTR_W = 16;

   localparam logic [3:0] OPC_NOP = 4'd0;
   localparam logic [3:0] OPC_ADD = 4'd1;
   localparam logic [3:0] OPC_SUB = 4'd2;
   localparam logic [3:0] OPC_AND = 4'd3;
   localparam logic [3:0] OPC_OR  = 4'd4;
   localparam logic [3:0] OPC_NOT = 4'd5;
   localparam logic [3:0] OPC_XOR = 4'd6;
   localparam logic [3:0] OPC_LDI = 4'd7;
   localparam logic [3:0] OPC_JMP = 4'd8;
   localparam logic [3:0] OPC_JC  = 4'd9;
   localparam logic [3:0] OPC_HLT = 4'd15;

   localparam logic [3:0] ALU_IDLE = 4'd0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // True for the six opcodes that run through the ALU and write back its result.
   function automatic logic opc_is_alu(input logic [3:0] opc);
      return (opc >= OPC_ADD) && (opc <= OPC_XOR);
   endfunction

endpackage

// File: rtl/control_unit_instr_decode.sv
// Pure opcode classifier: turns the 4-bit opcode field of the instruction
// register into the ALU opcode and one-hot instruction class flags.
module control_unit_instr_decode
   import control_unit_pkg::*;
(
   input  logic [3:0] opc,
   output logic [3:0] alu_op,
   output logic       is_alu,
   output logic       is_ldi,
   output logic       is_jmp,
   output logic       is_jc,
   output logic       is_hlt,
   output logic       is_illegal
);

   // Classify the opcode; everything not listed (10..14) is illegal.
   always_comb begin
      alu_op     = ALU_IDLE;
      is_alu     = 1'b0;
      is_ldi     = 1'b0;
      is_jmp     = 1'b0;
      is_jc      = 1'b0;
      is_hlt     = 1'b0;
      is_illegal = 1'b0;
      case (opc)
         OPC_NOP: ;
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_NOT, OPC_XOR: begin
            alu_op = opc;
            is_alu = opc_is_alu(opc);
         end
         OPC_LDI: is_ldi = 1'b1;
         OPC_JMP: is_jmp = 1'b1;
         OPC_JC:  is_jc  = 1'b1;
         OPC_HLT: is_hlt = 1'b1;
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 16-bit processor. Owns pc, ir, the carry flag
// and the halted/illegal status; decoded datapath controls are combinational
// from (state, ir).
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | after reset; waits for a start pulse
//  ST_FETCH  | prog_addr = pc, sync ROM captures the address
//  ST_DECODE | ir <= prog_data, pc <= pc + 1
//  ST_EXEC   | ALU settles; carry capture, jumps, illegal and halt resolved
//  ST_WB     | one-cycle register-file write (ALU ops and LDI only)
//  ST_HALT   | terminal; only rst leaves it
module control_unit
   import control_unit_pkg::*;
#(
   parameter int PC_W    = CU_PC_W,
   parameter int INSTR_W = CU_INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic [3:0]         alu_op,
   input  logic               alu_carry,
   output logic [3:0]         rf_ra,
   output logic [3:0]         rf_rb,
   output logic [3:0]         rf_wa,
   output logic               rf_we,
   output logic               wb_sel,
   output logic [7:0]         imm,
   output logic               carry_flag,
   output logic               halted,
   output logic               illegal
);

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   state_t             state;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;

   logic [3:0] dec_alu_op;
   logic       is_alu;
   logic       is_ldi;
   logic       is_jmp;
   logic       is_jc;
   logic       is_hlt;
   logic       is_illegal;

   control_unit_instr_decode u_decode (
      .opc        (ir[15:12]),
      .alu_op     (dec_alu_op),
      .is_alu     (is_alu),
      .is_ldi     (is_ldi),
      .is_jmp     (is_jmp),
      .is_jc      (is_jc),
      .is_hlt     (is_hlt),
      .is_illegal (is_illegal)
   );

   // Sequencer: state, pc, ir and the status flags all advance here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pc         <= '0;
         ir         <= '0;
         carry_flag <= 1'b0;
         halted     <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_FETCH;
            end
            ST_FETCH: begin
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               ir    <= prog_data;
               pc    <= pc + PC_ONE;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (is_alu) begin
                  carry_flag <= alu_carry;
                  state      <= ST_WB;
               end else if (is_ldi) begin
                  state <= ST_WB;
               end else if (is_jmp || (is_jc && carry_flag)) begin
                  pc    <= ir[PC_W-1:0];
                  state <= ST_FETCH;
               end else if (is_hlt) begin
                  halted <= 1'b1;
                  state  <= ST_HALT;
               end else begin
                  // NOP, untaken JC and illegal opcodes all just move on.
                  if (is_illegal) illegal <= 1'b1;
                  state <= ST_FETCH;
               end
            end
            ST_WB: begin
               state <= ST_FETCH;
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Field extraction is unconditional; ir is zero out of reset so these are too.
   assign prog_addr = pc;
   assign rf_ra     = ir[7:4];
   assign rf_rb     = ir[3:0];
   assign rf_wa     = ir[11:8];
   assign imm       = ir[7:0];

   // ALU opcode is held through WB so the write-back value stays stable.
   always_comb begin
      alu_op = ALU_IDLE;
      rf_we  = 1'b0;
      wb_sel = 1'b0;
      if ((state == ST_EXEC || state == ST_WB) && is_alu) alu_op = dec_alu_op;
      if (state == ST_WB) begin
         rf_we  = 1'b1;
         wb_sel = is_ldi;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: sync ROM, an instruction-level reference model that
// tracks each instruction as a sequence of cycles (3 or 4 long), a per-cycle
// compare against that model, and directed scenarios with literal expectations.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        alu_carry = 1'b0;
   logic [7:0]  prog_addr;
   logic [15:0] prog_data = 16'h0000;
   logic [3:0]  alu_op, rf_ra, rf_rb, rf_wa;
   logic        rf_we, wb_sel, carry_flag, halted, illegal;
   logic [7:0]  imm;

   logic [15:0] rom [0:255];

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;

   control_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .alu_op     (alu_op),
      .alu_carry  (alu_carry),
      .rf_ra      (rf_ra),
      .rf_rb      (rf_rb),
      .rf_wa      (rf_wa),
      .rf_we      (rf_we),
      .wb_sel     (wb_sel),
      .imm        (imm),
      .carry_flag (carry_flag),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) prog_data <= rom[prog_addr];

   always @(posedge clk) if (rf_we === 1'b1) we_cnt <= we_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_mode: 0 waiting for start, 1 running, 2 halted.
   // m_phase: cycle index inside the current instruction (0 = address out).
   int          m_mode  = 0;
   int          m_phase = 0;
   logic [7:0]  m_pc    = 8'h00;
   logic [15:0] m_cur   = 16'h0000;
   logic        m_carry = 1'b0;
   logic        m_ill   = 1'b0;
   logic [3:0]  mopc;
   assign mopc = m_cur[15:12];

   function automatic int cpi(input logic [3:0] opc);
      return (opc >= 4'd1 && opc <= 4'd7) ? 4 : 3;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode <= 0; m_phase <= 0; m_pc <= 8'h00;
         m_cur <= 16'h0000; m_carry <= 1'b0; m_ill <= 1'b0;
      end else if (m_mode == 0) begin
         if (start) begin m_mode <= 1; m_phase <= 0; end
      end else if (m_mode == 1) begin
         case (m_phase)
            0: m_phase <= 1;
            1: begin
               m_cur   <= rom[m_pc];
               m_pc    <= m_pc + 8'd1;
               m_phase <= 2;
            end
            2: begin
               if (mopc >= 4'd1 && mopc <= 4'd6) m_carry <= alu_carry;
               if (mopc >= 4'd10 && mopc <= 4'd14) m_ill <= 1'b1;
               if (mopc == 4'd8 || (mopc == 4'd9 && m_carry)) m_pc <= m_cur[7:0];
               if (mopc == 4'd15) m_mode <= 2;
               m_phase <= (cpi(mopc) == 4) ? 3 : 0;
            end
            default: m_phase <= 0;
         endcase
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      chk("prog_addr", prog_addr, m_pc);
      chk("alu_op", alu_op,
          (m_mode == 1 && m_phase >= 2 && mopc >= 4'd1 && mopc <= 4'd6) ? mopc : 4'd0);
      chk("rf_we", rf_we, (m_mode == 1 && m_phase == 3));
      chk("wb_sel", wb_sel, (m_mode == 1 && m_phase == 3 && mopc == 4'd7));
      chk("rf_wa", rf_wa, m_cur[11:8]);
      chk("rf_ra", rf_ra, m_cur[7:4]);
      chk("rf_rb", rf_rb, m_cur[3:0]);
      chk("imm", imm, m_cur[7:0]);
      chk("carry_flag", carry_flag, m_carry);
      chk("halted", halted, (m_mode == 2));
      chk("illegal", illegal, m_ill);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Cycles counted with the start cycle as 0; returns the cycle rf_we is seen.
   task automatic wait_we(output int n);
      n = 1;
      while (rf_we !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_halt(output int n);
      n = 0;
      while (halted !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;

      // Scenario A: LDI latency, ADD sets carry, taken JC, HLT ignores start.
      clear_rom();
      rom[8'h00] = 16'h7105;
      rom[8'h01] = 16'h1211;
      rom[8'h02] = 16'h9020;
      rom[8'h20] = 16'h0000;
      rom[8'h21] = 16'hF000;
      alu_carry = 1'b1;
      do_reset();
      chk("rst_prog_addr", prog_addr, 8'h00);
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_carry", carry_flag, 1'b0);
      chk("rst_halted", halted, 1'b0);
      tick();
      pulse_start();
      wait_we(n);
      chk("ldi_latency", n, 4);
      chk("ldi_wa", rf_wa, 4'd1);
      chk("ldi_wb_sel", wb_sel, 1'b1);
      chk("ldi_imm", imm, 8'h05);
      chk("ldi_pc", prog_addr, 8'h01);
      tick();
      wait_we(n);
      chk("add_latency", n, 4);
      chk("add_alu_op", alu_op, 4'd1);
      chk("add_carry", carry_flag, 1'b1);
      chk("add_wb_sel", wb_sel, 1'b0);
      repeat (4) tick();
      chk("jc_taken_addr", prog_addr, 8'h20);
      wait_halt(n);
      chk("halt_reached", halted, 1'b1);
      pulse_start();
      repeat (3) tick();
      chk("halt_stays", halted, 1'b1);
      chk("halt_pc", prog_addr, 8'h22);

      // Scenario B: untaken JC, JMP to FF, NOP at FF wraps pc to 0.
      clear_rom();
      rom[8'h00] = 16'h9020;
      rom[8'h01] = 16'h80FF;
      rom[8'hFF] = 16'h0000;
      alu_carry = 1'b0;
      do_reset();
      tick();
      we_cnt = 0;
      pulse_start();
      repeat (3) tick();
      chk("jc_untaken_addr", prog_addr, 8'h01);
      chk("jc_carry_kept", carry_flag, 1'b0);
      repeat (3) tick();
      chk("jmp_addr", prog_addr, 8'hFF);
      repeat (3) tick();
      chk("wrap_addr", prog_addr, 8'h00);
      chk("b_no_we", we_cnt, 0);

      // Scenario C: illegal opcode is sticky and never writes.
      clear_rom();
      rom[8'h00] = 16'hA123;
      rom[8'h01] = 16'h7207;
      rom[8'h02] = 16'hF000;
      do_reset();
      tick();
      we_cnt = 0;
      pulse_start();
      repeat (3) tick();
      chk("ill_set", illegal, 1'b1);
      chk("ill_no_we", we_cnt, 0);
      chk("ill_next_addr", prog_addr, 8'h01);
      wait_halt(n);
      chk("ill_sticky", illegal, 1'b1);
      chk("ill_one_we", we_cnt, 1);
      chk("ill_halted", halted, 1'b1);

      // Scenario D: reset during WB of an ADD.
      clear_rom();
      rom[8'h00] = 16'h1211;
      alu_carry = 1'b1;
      do_reset();
      tick();
      pulse_start();
      wait_we(n);
      chk("d_latency", n, 4);
      chk("d_carry_set", carry_flag, 1'b1);
      rst = 1'b1;
      #1;
      chk("d_we_drop", rf_we, 1'b0);
      chk("d_alu_op", alu_op, 4'd0);
      chk("d_carry_clr", carry_flag, 1'b0);
      chk("d_pc_clr", prog_addr, 8'h00);
      chk("d_wa_clr", rf_wa, 4'd0);
      tick();
      tick();
      rst = 1'b0;
      we_cnt = 0;
      repeat (6) tick();
      chk("d_idle_no_we", we_cnt, 0);
      chk("d_idle_pc", prog_addr, 8'h00);
      pulse_start();
      wait_we(n);
      chk("d_resume_latency", n, 4);
      chk("d_resume_pc", prog_addr, 8'h01);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
